pulse_event_arbiter: RTL and testbench

Multi-channel pulse scheduler. Detects qualified 0->1 transitions on N_CH level inputs, queues one pending event per channel and shares a single event output among the channels with round-robin fairness. The output uses a valid/ready handshake. Sits between raw level sources (sensors, buttons, status lines) and one downstream event consumer.

---
 rtl/pulse_event_arbiter.sv | 90 +++++++++
 tb/tb_pulse_event_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_event_arbiter.sv
// Rising-edge event collector: one pending slot per channel, one shared
// valid/ready output granted round-robin starting after the last winner.
module pulse_event_arbiter #(
  parameter int N_CH = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] x_in,
  input  logic [N_CH-1:0] ch_en,
  input  logic            ovf_clr,
  input  logic            evt_ready,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  output logic [N_CH-1:0] ovf,
  output logic            busy
);

  logic [N_CH-1:0] prev_reg;
  logic [N_CH-1:0] pend_reg;
  logic [N_CH-1:0] ovf_reg;
  logic [ID_W-1:0] rr_ptr_reg;
  logic            evt_valid_reg;
  logic [ID_W-1:0] evt_id_reg;

  logic [N_CH-1:0] edge_det;
  logic [N_CH-1:0] load_mask;
  logic [N_CH-1:0] ovf_new;
  logic [N_CH-1:0] pend_next;
  logic [N_CH-1:0] ovf_next;
  logic            slot_free;
  logic            load;
  logic            sel_found;
  logic [ID_W-1:0] sel_id;
  int              idx;

  assign slot_free = ~evt_valid_reg | evt_ready;
  assign load      = slot_free & sel_found;

  // Search order starts one past the last granted channel and wraps at N_CH.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(rr_ptr_reg) + k) % N_CH;
      if (!sel_found && pend_reg[idx[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = idx[ID_W-1:0];
      end
    end
  end

  // A fresh edge on the channel being loaded re-arms pend rather than overflowing.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign edge_det[gi]  = x_in[gi] & ~prev_reg[gi] & ch_en[gi];
    assign load_mask[gi] = load & (sel_id == ID_W'(gi));
    assign ovf_new[gi]   = edge_det[gi] & pend_reg[gi] & ~load_mask[gi];
    assign pend_next[gi] = (pend_reg[gi] & ~load_mask[gi]) | edge_det[gi];
    assign ovf_next[gi]  = (ovf_reg[gi] & ~ovf_clr) | ovf_new[gi];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_reg      <= '1;
      pend_reg      <= '0;
      ovf_reg       <= '0;
      rr_ptr_reg    <= ID_W'(N_CH - 1);
      evt_valid_reg <= 1'b0;
      evt_id_reg    <= '0;
    end else begin
      prev_reg <= x_in;
      pend_reg <= pend_next;
      ovf_reg  <= ovf_next;
      if (slot_free) begin
        evt_valid_reg <= sel_found;
        if (sel_found) begin
          evt_id_reg <= sel_id;
          rr_ptr_reg <= sel_id;
        end
      end
    end
  end

  assign evt_valid = evt_valid_reg;
  assign evt_id    = evt_id_reg;
  assign ovf       = ovf_reg;
  assign busy      = (|pend_reg) | evt_valid_reg;

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Bench for pulse_event_arbiter: directed scenarios plus random traffic,
// all compared against an event-level reference model.
module tb_pulse_event_arbiter;
  localparam int N_CH = 4;
  localparam int ID_W = 2;
  localparam int VW   = N_CH + ID_W + 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N_CH-1:0] x_in = '0;
  logic [N_CH-1:0] ch_en = '1;
  logic            ovf_clr = 1'b0;
  logic            evt_ready = 1'b0;
  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic [N_CH-1:0] ovf;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;
  int acc[$];

  pulse_event_arbiter #(.N_CH(N_CH), .ID_W(ID_W)) dut (
    .clk(clk), .reset_n(reset_n), .x_in(x_in), .ch_en(ch_en), .ovf_clr(ovf_clr),
    .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_id(evt_id), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel flags and the last granted channel number.
  bit m_prev[N_CH];
  bit m_pend[N_CH];
  bit m_ovf[N_CH];
  bit m_valid;
  int m_id;
  int m_rr;
  bit m_free;
  int m_load;

  always_comb begin
    m_free = !m_valid || evt_ready;
    m_load = -1;
    if (m_free)
      for (int k = 1; k <= N_CH; k++)
        if (m_load < 0 && m_pend[(m_rr + k) % N_CH]) m_load = (m_rr + k) % N_CH;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        m_prev[i] <= 1'b1;
        m_pend[i] <= 1'b0;
        m_ovf[i]  <= 1'b0;
      end
      m_valid <= 1'b0;
      m_id    <= 0;
      m_rr    <= N_CH - 1;
    end else begin
      if (m_free) begin
        m_valid <= (m_load >= 0);
        if (m_load >= 0) begin
          m_id <= m_load;
          m_rr <= m_load;
        end
      end
      for (int i = 0; i < N_CH; i++) begin
        if (i == m_load) m_pend[i] <= x_in[i] && !m_prev[i] && ch_en[i];
        else if (x_in[i] && !m_prev[i] && ch_en[i]) m_pend[i] <= 1'b1;
        if (x_in[i] && !m_prev[i] && ch_en[i] && m_pend[i] && i != m_load) m_ovf[i] <= 1'b1;
        else if (ovf_clr) m_ovf[i] <= 1'b0;
        m_prev[i] <= x_in[i];
      end
    end
  end

  always @(posedge clk)
    if (reset_n && evt_valid && evt_ready) acc.push_back(int'(evt_id));

  function automatic logic [VW-1:0] dut_vec();
    return {evt_valid, evt_valid ? evt_id : ID_W'(0), ovf, busy};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [N_CH-1:0] o;
    logic b;
    b = m_valid;
    for (int i = 0; i < N_CH; i++) begin
      o[i] = m_ovf[i];
      b = b | m_pend[i];
    end
    return {m_valid, m_valid ? ID_W'(m_id) : ID_W'(0), o, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [N_CH-1:0] x);
    x_in = x;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    int base;
    x_in = 4'b0001;
    evt_ready = 1'b1;
    reset_n = 1'b0;
    tick();
    n_checks++;
    if (dut_vec() !== VW'(0) || evt_id !== '0) $display("FAIL reset_state got %h id %0d want 0", dut_vec(), evt_id);
    else n_pass++;
    reset_n = 1'b1;
    base = acc.size();
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (evt_valid !== 1'b0 || dut_vec() !== model_vec()) $display("FAIL held_high cyc %0d got %h want %h", c, dut_vec(), model_vec());
      else n_pass++;
    end
    x_in = 4'b0000;
    tick();
    x_in = 4'b0001;
    tick();
    n_checks++;
    if (evt_valid !== 1'b0) $display("FAIL latency_c1 got valid %b want 0", evt_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0) $display("FAIL latency_c2 got valid %b id %0d want 1 id 0", evt_valid, evt_id);
    else n_pass++;
    for (int c = 0; c < 3; c++) tick();
    n_checks++;
    if (acc.size() - base !== 1 || dut_vec() !== model_vec()) $display("FAIL single_event got %0d events want 1", acc.size() - base);
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    do_reset('0);
    evt_ready = 1'b1;
    ch_en = '1;
    x_in = 4'hF;
    tick();
    for (int c = 2; c <= 6; c++) begin
      tick();
      n_checks++;
      if (c <= 5 && (evt_valid !== 1'b1 || int'(evt_id) !== c - 2))
        $display("FAIL b2b cyc %0d got valid %b id %0d want 1 id %0d", c, evt_valid, evt_id, c - 2);
      else if (c == 6 && (evt_valid !== 1'b0 || busy !== 1'b0))
        $display("FAIL b2b_idle got valid %b busy %b want 0 0", evt_valid, busy);
      else n_pass++;
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_backpressure();
    int base;
    do_reset('0);
    evt_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      x_in = 4'b0100;
      tick();
      x_in = 4'b0000;
      tick();
      n_checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd2 || ovf !== (p == 2 ? 4'b0100 : 4'b0000) || dut_vec() !== model_vec())
        $display("FAIL hold pulse %0d got %h want %h", p, dut_vec(), model_vec());
      else n_pass++;
    end
    base = acc.size();
    evt_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    n_checks++;
    if (acc.size() - base !== 2 || acc[base] !== 2 || acc[base + 1] !== 2)
      $display("FAIL drain got %0d events want 2 of id 2", acc.size() - base);
    else n_pass++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_checks++;
    if (ovf !== 4'b0000 || dut_vec() !== model_vec()) $display("FAIL ovf_clr got %b want 0000", ovf);
    else n_pass++;
    $display("test_backpressure done");
  endtask

  task automatic test_fairness();
    int base;
    int bad;
    do_reset('0);
    evt_ready = 1'b1;
    base = acc.size();
    for (int p = 0; p < 6; p++) begin
      x_in = 4'b0011;
      tick();
      x_in = 4'b0000;
      tick();
      tick();
      tick();
    end
    for (int c = 0; c < 3; c++) tick();
    bad = 0;
    for (int j = 0; j < 12 && base + j < acc.size(); j++) if (acc[base + j] !== j % 2) bad++;
    n_checks++;
    if (acc.size() - base !== 12 || bad != 0 || ovf !== 4'b0000)
      $display("FAIL fairness got %0d events %0d out of order ovf %b want 12 0 0000", acc.size() - base, bad, ovf);
    else n_pass++;
    $display("test_fairness done");
  endtask

  task automatic test_ch_en();
    int base;
    do_reset('0);
    evt_ready = 1'b1;
    ch_en = 4'b1110;
    base = acc.size();
    x_in = 4'b0001;
    tick();
    x_in = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (evt_valid !== 1'b0 || busy !== 1'b0) $display("FAIL disabled cyc %0d got valid %b busy %b want 0 0", c, evt_valid, busy);
      else n_pass++;
    end
    x_in = 4'b1000;
    tick();
    x_in = 4'b0000;
    for (int c = 0; c < 4; c++) tick();
    n_checks++;
    if (acc.size() - base !== 1 || acc[acc.size() - 1] !== 3)
      $display("FAIL enabled_ch3 got %0d events want 1 of id 3", acc.size() - base);
    else n_pass++;
    ch_en = '1;
    $display("test_ch_en done");
  endtask

  task automatic test_async_reset();
    int base;
    do_reset('0);
    evt_ready = 1'b0;
    x_in = 4'b0001;
    tick();
    x_in = 4'b0000;
    tick();
    x_in = 4'b1010;
    tick();
    x_in = 4'b0000;
    tick();
    n_checks++;
    if (evt_valid !== 1'b1 || busy !== 1'b1 || dut_vec() !== model_vec()) $display("FAIL pre_reset got %h want %h", dut_vec(), model_vec());
    else n_pass++;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (evt_valid !== 1'b0 || busy !== 1'b0) $display("FAIL async_reset got valid %b busy %b want 0 0", evt_valid, busy);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    evt_ready = 1'b1;
    base = acc.size();
    for (int c = 0; c < 6; c++) tick();
    n_checks++;
    if (acc.size() - base !== 0 || evt_valid !== 1'b0 || busy !== 1'b0) $display("FAIL stale got %0d events want 0", acc.size() - base);
    else n_pass++;
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    int errs;
    do_reset('0);
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      x_in = N_CH'($urandom);
      ch_en = ($urandom_range(0, 3) == 0) ? N_CH'($urandom) : '1;
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        errs++;
        if (errs < 10) $display("FAIL random cyc %0d got %h want %h", c, dut_vec(), model_vec());
      end else n_pass++;
    end
    ovf_clr = 1'b0;
    ch_en = '1;
    $display("test_random done");
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_fairness();
    test_ch_en();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
